// File: rtl/window_max_tracker.sv
// Windowed running-maximum tracker built around a gate-level
// 4-bit magnitude comparator; publishes max and index per window.
module fourbit_greater_than (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt
);
    logic [3:0] w_eq;
    logic [3:0] w_win;

    assign w_eq  = ~(a ^ b);
    assign w_win = a & ~b;

    // Decide at the most significant bit position where a and b differ
    assign gt = w_win[3]
              | (w_eq[3] & w_win[2])
              | (w_eq[3] & w_eq[2] & w_win[1])
              | (w_eq[3] & w_eq[2] & w_eq[1] & w_win[0]);
endmodule

module window_max_tracker #(
    parameter int WINDOW = 8,
    parameter int IDX_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic [3:0]       res_max,
    output logic [IDX_W-1:0] res_idx,
    output logic             res_valid,
    output logic             done_tick,
    output logic             busy
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WINDOW - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_cnt;
    logic [3:0]       r_cur_max;
    logic [IDX_W-1:0] r_cur_idx;
    logic [3:0]       r_res_max;
    logic [IDX_W-1:0] r_res_idx;
    logic             r_res_valid;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic             w_gt;
    logic             w_finish;

    fourbit_greater_than u_cmp (
        .a  (in_data),
        .b  (r_cur_max),
        .gt (w_gt)
    );

    assign w_accept = in_valid & ~clr;
    assign w_last   = (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        if (clr) begin
            w_state_nxt = IDLE;
        end else if (w_accept) begin
            unique case (r_state)
                IDLE: w_state_nxt = RUN;
                RUN: begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_finish    = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_cur_max   <= '0;
            r_cur_idx   <= '0;
            r_res_max   <= '0;
            r_res_idx   <= '0;
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (clr) begin
                r_cnt     <= '0;
                r_cur_max <= '0;
                r_cur_idx <= '0;
            end else if (w_accept) begin
                if (r_state == IDLE) begin
                    r_cur_max <= in_data;
                    r_cur_idx <= '0;
                    r_cnt     <= IDX_W'(1);
                end else if (w_last) begin
                    r_res_max   <= w_gt ? in_data : r_cur_max;
                    r_res_idx   <= w_gt ? r_cnt : r_cur_idx;
                    r_res_valid <= 1'b1;
                    r_cnt       <= '0;
                end else begin
                    if (w_gt) begin
                        r_cur_max <= in_data;
                        r_cur_idx <= r_cnt;
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign res_max   = r_res_max;
    assign res_idx   = r_res_idx;
    assign res_valid = r_res_valid;
    assign done_tick = r_done;
    assign busy      = (r_state == RUN);
endmodule

// File: tb/tb_window_max_tracker.sv
// Self-checking bench for window_max_tracker: expected window results
// are queued with the stimulus and compared when done_tick fires.
module tb_window_max_tracker;
    logic       clk;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic [3:0] in_data;
    logic [3:0] res_max;
    logic [2:0] res_idx;
    logic       res_valid;
    logic       done_tick;
    logic       busy;

    int n_pass;
    int n_total;

    logic [3:0] q_max[$];
    logic [2:0] q_idx[$];

    window_max_tracker #(.WINDOW(8), .IDX_W(3)) dut (
        .clk       (clk),
        .reset     (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .res_max   (res_max),
        .res_idx   (res_idx),
        .res_valid (res_valid),
        .done_tick (done_tick),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_win(input logic [3:0] m, input logic [2:0] i);
        q_max.push_back(m);
        q_idx.push_back(i);
    endtask

    // Drive one cycle, then score any published window result
    task automatic drive(input logic v, input logic [3:0] d,
                         input logic c);
        logic [3:0] em;
        logic [2:0] ei;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clr      = c;
        @(posedge clk);
        #1;
        if (done_tick === 1'b1) begin
            n_total++;
            if (q_max.size() == 0) begin
                $display("FAIL sb_unexpected_done: res_max=%0d res_idx=%0d, required no done",
                         res_max, res_idx);
            end else begin
                em = q_max.pop_front();
                ei = q_idx.pop_front();
                if (res_max !== em || res_idx !== ei || res_valid !== 1'b1)
                    $display("FAIL sb_result: max=%0d idx=%0d vld=%b, required max=%0d idx=%0d vld=1",
                             res_max, res_idx, res_valid, em, ei);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 4'd0;
        #3;
        n_total++;
        if ({res_max, res_idx, res_valid, done_tick, busy} !== 10'd0)
            $display("FAIL reset_state: outs=%b, required 0", {res_max, res_idx, res_valid, done_tick, busy});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'd0, 1'b0);
            n_total++;
            if ({done_tick, busy, res_valid} !== 3'b000)
                $display("FAIL reset_idle: done/busy/vld=%b, required 000", {done_tick, busy, res_valid});
            else n_pass++;
        end
    endtask

    task automatic test_basic;
        logic [3:0] s[8];
        s = '{4'd3, 4'd9, 4'd2, 4'd9, 4'd15, 4'd0, 4'd15, 4'd1};
        expect_win(4'd15, 3'd4);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, s[k], 1'b0);
            n_total++;
            if (done_tick !== (k == 7) || busy !== (k != 7))
                $display("FAIL basic_edge%0d: done=%b busy=%b, required done=%b busy=%b",
                         k, done_tick, busy, (k == 7), (k != 7));
            else n_pass++;
        end
        drive(1'b0, 4'd0, 1'b0);
        n_total++;
        if (done_tick !== 1'b0 || res_max !== 4'd15 || res_idx !== 3'd4 || res_valid !== 1'b1)
            $display("FAIL basic_hold: done=%b max=%0d idx=%0d vld=%b, required 0/15/4/1",
                     done_tick, res_max, res_idx, res_valid);
        else n_pass++;
    endtask

    task automatic test_gaps;
        expect_win(4'd0, 3'd0);
        for (int k = 0; k < 16; k++) begin
            drive((k % 2) == 0, 4'd0, 1'b0);
            n_total++;
            if (done_tick !== (k == 14))
                $display("FAIL gaps_cyc%0d: done=%b, required %b", k, done_tick, (k == 14));
            else n_pass++;
        end
    endtask

    task automatic test_clr_mid;
        logic [3:0] a[8];
        a = '{4'd1, 4'd3, 4'd7, 4'd2, 4'd7, 4'd0, 4'd5, 4'd6};
        expect_win(4'd7, 3'd2);
        for (int k = 0; k < 8; k++) drive(1'b1, a[k], 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b1, 4'd4, 1'b0);
        n_total++;
        if (busy !== 1'b1)
            $display("FAIL clr_busy_before: busy=%b, required 1", busy);
        else n_pass++;
        drive(1'b1, 4'd15, 1'b1);
        n_total++;
        if (busy !== 1'b0 || done_tick !== 1'b0 || res_max !== 4'd7 || res_idx !== 3'd2)
            $display("FAIL clr_retain: busy=%b done=%b max=%0d idx=%0d, required 0/0/7/2",
                     busy, done_tick, res_max, res_idx);
        else n_pass++;
        expect_win(4'd14, 3'd7);
        for (int k = 0; k < 8; k++) drive(1'b1, (k == 7) ? 4'd14 : 4'd1, 1'b0);
        n_total++;
        if (done_tick !== 1'b1)
            $display("FAIL clr_next_done: done=%b, required 1", done_tick);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [3:0] b[8];
        b = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd15};
        expect_win(4'd5, 3'd0);
        expect_win(4'd15, 3'd7);
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, (k < 8) ? 4'd5 : b[k-8], 1'b0);
            n_total++;
            if (done_tick !== (k == 7 || k == 15))
                $display("FAIL b2b_edge%0d: done=%b, required %b", k + 1, done_tick, (k == 7 || k == 15));
            else n_pass++;
        end
    endtask

    task automatic test_clr_final;
        logic [3:0] c[8];
        for (int k = 0; k < 7; k++) drive(1'b1, 4'd9, 1'b0);
        drive(1'b1, 4'd12, 1'b1);
        n_total++;
        if (done_tick !== 1'b0 || busy !== 1'b0 || res_max !== 4'd15 || res_idx !== 3'd7)
            $display("FAIL clrfin_abort: done=%b busy=%b max=%0d idx=%0d, required 0/0/15/7",
                     done_tick, busy, res_max, res_idx);
        else n_pass++;
        c = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd8, 4'd1};
        expect_win(4'd8, 3'd5);
        for (int k = 0; k < 8; k++) drive(1'b1, c[k], 1'b0);
        n_total++;
        if (done_tick !== 1'b1)
            $display("FAIL clrfin_next_done: done=%b, required 1", done_tick);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        for (int k = 0; k < 3; k++) drive(1'b1, 4'd6, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({res_max, res_idx, res_valid, done_tick, busy} !== 10'd0)
            $display("FAIL async_reset: outs=%b, required 0", {res_max, res_idx, res_valid, done_tick, busy});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_gaps();
        test_clr_mid();
        test_back_to_back();
        test_clr_final();
        test_async_reset();
        n_total++;
        if (q_max.size() != 0)
            $display("FAIL sb_missing_done: pending=%0d, required 0", q_max.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
